// File: rtl/digit_scan_scheduler.sv
// Eight-digit multiplexed display scan: one shared BCD decoder, fixed round-robin slots,
// a dead-time guard before each anode turns on, and per-frame snapshotting of the inputs.
module digit_scan_scheduler #(
   parameter int GUARD_CYCLES = 4
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        tick,
   input  logic [31:0] digits,
   input  logic [7:0]  digit_en,
   input  logic        blank_lz,
   output logic [7:0]  AN,
   output logic [3:0]  bcd_out,
   output logic [2:0]  digit_idx,
   output logic        frame_done
);

   localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, GUARD, ON} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] guard_cnt;
   logic [31:0]      snap_digits;
   logic [7:0]       snap_en;
   logic             snap_blz;

   logic             advance;
   logic [2:0]       idx_nxt;
   logic             load_snap;
   logic             guard_done;
   logic [7:0]       zero_from;
   logic [7:0]       visible;

   // Ticks are only honoured in IDLE and ON; GUARD drops them.
   assign advance    = tick && ((state == IDLE) || (state == ON));
   assign idx_nxt    = (state == IDLE) ? 3'd0 : digit_idx + 3'd1;
   assign load_snap  = advance && (idx_nxt == 3'd0);
   assign guard_done = (state == GUARD) && (guard_cnt == CNT_LAST);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, ON: begin
            if (tick) begin
               state_nxt = (GUARD_CYCLES == 0) ? ON : GUARD;
            end
         end
         GUARD: begin
            if (guard_done) begin
               state_nxt = ON;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         digit_idx   <= 3'd0;
         bcd_out     <= 4'h0;
         frame_done  <= 1'b0;
         guard_cnt   <= '0;
         snap_digits <= 32'h0;
         snap_en     <= 8'h0;
         snap_blz    <= 1'b0;
      end else begin
         frame_done <= advance && (state == ON) && (digit_idx == 3'd7);
         if (advance) begin
            digit_idx <= idx_nxt;
            guard_cnt <= '0;
            // Slot 0 shows the freshly captured value, not the stale snapshot.
            bcd_out   <= load_snap ? digits[{idx_nxt, 2'b00} +: 4]
                                   : snap_digits[{idx_nxt, 2'b00} +: 4];
         end else if ((state == GUARD) && !guard_done) begin
            guard_cnt <= guard_cnt + 1'b1;
         end
         if (load_snap) begin
            snap_digits <= digits;
            snap_en     <= digit_en;
            snap_blz    <= blank_lz;
         end
      end
   end

   // zero_from[i] is set when snapshot nibbles i..7 are all zero.
   always_comb begin
      logic above;
      above     = 1'b1;
      zero_from = 8'h00;
      visible   = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         above        = above && (snap_digits[4*i +: 4] == 4'h0);
         zero_from[i] = above;
      end
      for (int i = 0; i < 8; i++) begin
         visible[i] = snap_en[i] && !(snap_blz && (i != 0) && zero_from[i]);
      end
   end

   always_comb begin
      AN = 8'hFF;
      if ((state == ON) && visible[digit_idx]) begin
         AN[digit_idx] = 1'b0;
      end
   end

endmodule

// File: tb/tb_digit_scan_scheduler.sv
// Bench for digit_scan_scheduler: a GUARD_CYCLES=4 instance and a GUARD_CYCLES=0 instance
// driven from a table of frames, plus hand sequences for guard-tick and reset corners.
module tb_digit_scan_scheduler;

   localparam int GUARD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        tick;
   logic        tick0;
   logic [31:0] digits;
   logic [7:0]  digit_en;
   logic        blank_lz;
   logic [7:0]  an4, an0;
   logic [3:0]  bcd4, bcd0;
   logic [2:0]  idx4, idx0;
   logic        fd4, fd0;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] digits;
      logic [7:0]  en;
      logic        blz;
      logic [7:0]  vis;
   } vec_t;

   typedef struct {
      logic [2:0] idx;
      logic [3:0] bcd;
      logic [7:0] an;
      logic       fd;
   } exp_t;

   vec_t vecs[8];
   exp_t sbq[$];

   always #5 clk = ~clk;

   digit_scan_scheduler #(.GUARD_CYCLES(GUARD)) dut (
      .clk_in(clk), .reset(reset), .tick(tick), .digits(digits), .digit_en(digit_en),
      .blank_lz(blank_lz), .AN(an4), .bcd_out(bcd4), .digit_idx(idx4), .frame_done(fd4)
   );

   digit_scan_scheduler #(.GUARD_CYCLES(0)) dut0 (
      .clk_in(clk), .reset(reset), .tick(tick0), .digits(digits), .digit_en(digit_en),
      .blank_lz(blank_lz), .AN(an0), .bcd_out(bcd0), .digit_idx(idx0), .frame_done(fd0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // At most one anode may be low on either instance at any time.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         check("onehot_g4", ($countones(~an4) <= 1) ? 1 : 0, 1);
         check("onehot_g0", ($countones(~an0) <= 1) ? 1 : 0, 1);
      end
   end

   task automatic do_tick(input logic [2:0] k, input logic [31:0] d, input logic [7:0] vis,
                          input logic fd_exp);
      exp_t e;
      e.idx = k;
      e.bcd = d[{k, 2'b00} +: 4];
      e.an  = vis[k] ? ~(8'h01 << k) : 8'hFF;
      e.fd  = fd_exp;
      sbq.push_back(e);
      @(negedge clk);
      tick  = 1'b1;
      tick0 = 1'b1;
      @(posedge clk);
      #1;
      tick  = 1'b0;
      tick0 = 1'b0;
      if (sbq.size() == 0) begin
         check("sb_empty", 1, 0);
         return;
      end
      e = sbq.pop_front();
      check("idx_g4", idx4, e.idx);
      check("bcd_g4", bcd4, e.bcd);
      check("fd_g4", fd4, e.fd);
      check("an_guard_t1", an4, 8'hFF);
      check("idx_g0", idx0, e.idx);
      check("bcd_g0", bcd0, e.bcd);
      check("fd_g0", fd0, e.fd);
      check("an_g0_t1", an0, e.an);
      for (int c = 2; c <= GUARD; c++) begin
         @(posedge clk);
         #1;
         check("an_guard", an4, 8'hFF);
         if (c == 2) check("fd_one_cycle", fd4, 0);
      end
      @(posedge clk);
      #1;
      check("an_on_g4", an4, e.an);
      check("an_on_g0", an0, e.an);
      check("idx_hold", idx4, e.idx);
   endtask

   task automatic run_frame(input vec_t v, input logic first);
      digits   = v.digits;
      digit_en = v.en;
      blank_lz = v.blz;
      for (int k = 0; k < 8; k++) begin
         do_tick(3'(k), v.digits, v.vis, (k == 0) && !first);
         // Scramble inputs mid-frame; the snapshot must hide this until next slot 0.
         if (k == 3) begin
            digits   = $urandom;
            digit_en = 8'($urandom);
            blank_lz = 1'($urandom);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      vecs[0] = '{32'h76543210, 8'hFF, 1'b0, 8'hFF};
      vecs[1] = '{32'h00000120, 8'hFF, 1'b1, 8'h07};
      vecs[2] = '{32'h00000000, 8'hFF, 1'b1, 8'h01};
      vecs[3] = '{32'h00000000, 8'hFF, 1'b0, 8'hFF};
      vecs[4] = '{32'hA0000000, 8'hFF, 1'b1, 8'hFF};
      vecs[5] = '{32'h12345678, 8'h5A, 1'b0, 8'h5A};
      vecs[6] = '{32'h00F00000, 8'hF0, 1'b1, 8'h30};
      vecs[7] = '{32'h00000009, 8'hFF, 1'b1, 8'h01};

      reset    = 1'b1;
      tick     = 1'b0;
      tick0    = 1'b0;
      digits   = 32'h0;
      digit_en = 8'h0;
      blank_lz = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_an", an4, 8'hFF);
      check("rst_bcd", bcd4, 4'h0);
      check("rst_idx", idx4, 3'd0);
      check("rst_fd", fd4, 1'b0);
      check("rst_an_g0", an0, 8'hFF);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_an", an4, 8'hFF);

      for (int f = 0; f < 8; f++) begin
         run_frame(vecs[f], f == 0);
      end

      // Tick two cycles into GUARD must be dropped (only the G=4 instance sees it).
      digits   = 32'h76543210;
      digit_en = 8'hFF;
      blank_lz = 1'b0;
      @(negedge clk);
      tick  = 1'b1;
      tick0 = 1'b1;
      @(posedge clk);
      #1;
      tick  = 1'b0;
      tick0 = 1'b0;
      check("gt_idx_t1", idx4, 3'd0);
      check("gt_fd_t1", fd4, 1'b1);
      @(posedge clk);
      #1;
      @(negedge clk);
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      check("gt_idx_t3", idx4, 3'd0);
      check("gt_an_t3", an4, 8'hFF);
      @(posedge clk);
      #1;
      check("gt_an_t4", an4, 8'hFF);
      @(posedge clk);
      #1;
      check("gt_an_t5", an4, 8'hFE);
      check("gt_idx_t5", idx4, 3'd0);

      for (int k = 1; k < 5; k++) do_tick(3'(k), 32'h76543210, 8'hFF, 1'b0);

      // Advance to slot 5, then reset mid-GUARD together with a tick.
      @(negedge clk);
      tick  = 1'b1;
      tick0 = 1'b1;
      @(posedge clk);
      #1;
      tick  = 1'b0;
      tick0 = 1'b0;
      check("pre_rst_idx", idx4, 3'd5);
      check("pre_rst_bcd", bcd4, 4'h5);
      @(negedge clk);
      reset = 1'b1;
      tick  = 1'b1;
      tick0 = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick  = 1'b0;
      tick0 = 1'b0;
      check("mid_rst_an", an4, 8'hFF);
      check("mid_rst_idx", idx4, 3'd0);
      check("mid_rst_bcd", bcd4, 4'h0);
      check("mid_rst_fd", fd4, 1'b0);
      check("mid_rst_idx_g0", idx0, 3'd0);
      repeat (GUARD + 2) @(posedge clk);
      #1;
      check("post_rst_idle_an", an4, 8'hFF);
      check("post_rst_idle_an_g0", an0, 8'hFF);

      v = '{32'h00000305, 8'hFF, 1'b1, 8'h07};
      run_frame(v, 1'b1);
      v = '{32'h11111111, 8'hFF, 1'b0, 8'hFF};
      run_frame(v, 1'b0);
      v = '{32'h22222222, 8'hFF, 1'b0, 8'hFF};
      run_frame(v, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/digit_scan_scheduler.md
DIGIT_SCAN_SCHEDULER -- requirements
Module: digit_scan_scheduler

Interface
REQ-001 Parameter: GUARD_CYCLES, default 4, number of clk_in cycles all anodes are held off before each digit is lit (legal 0..255).
REQ-002 Port: clk_in  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: tick  input  1  refresh strobe, one-cycle pulse from the fast clock divider; advances the scan.
REQ-005 Port: digits  input  32  eight BCD nibbles; digits[4i+3:4i] is the value for digit i (digit 0 = rightmost).
REQ-006 Port: digit_en  input  8  per-digit enable mask; 0 keeps that anode off for its whole slot.
REQ-007 Port: blank_lz  input  1  1 = suppress leading zeros.
REQ-008 Port: AN  output  8  active-low anode drive; at most one bit low at any time.
REQ-009 Port: bcd_out  output  4  nibble routed to the shared BCD-to-seven-segment decoder.
REQ-010 Port: digit_idx  output  3  index of the digit currently scheduled.
REQ-011 Port: frame_done  output  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

Function
REQ-012 The block SHALL time-share one seven-segment decoder among 8 digits with a fixed 8-slot round-robin scan; disabled or blanked digits still consume their slot, so the refresh rate is constant.
REQ-013 States SHALL be IDLE (after reset, before first tick), GUARD and ON.
REQ-014 IDLE: AN=8'hFF; a tick SHALL capture the snapshot, set digit_idx=0 and enter GUARD.
REQ-015 In ON, a tick SHALL advance digit_idx by 1 modulo 8 and enter GUARD; from 7 it SHALL wrap to 0.
REQ-016 The snapshot register SHALL load digits, digit_en and blank_lz only on entry to slot 0, including from IDLE; slots 1..7 use the snapshot, so a frame never tears.
REQ-017 bcd_out and digit_idx SHALL update in the cycle after the tick (t+1); bcd_out = snapshot nibble of the new digit_idx.
REQ-018 GUARD SHALL hold AN=8'hFF for exactly GUARD_CYCLES cycles (t+1 .. t+GUARD_CYCLES), then enter ON; with GUARD_CYCLES=0, GUARD SHALL be skipped and ON entered at t+1.
REQ-019 In ON, AN[digit_idx]=0 iff the digit is visible; all other bits SHALL be 1.
REQ-020 Digit i is visible iff snapshot digit_en[i]=1 and not blanked; it is blanked iff snapshot blank_lz=1, i!=0, and snapshot nibbles i..7 are all zero.
REQ-021 Digit 0 SHALL never be leading-zero blanked.
REQ-022 Ticks arriving in GUARD SHALL be ignored (not queued); a tick in the cycle ON is entered SHALL be honored.
REQ-023 frame_done SHALL pulse for exactly one cycle at t+1 of the tick causing the 7->0 wrap; it SHALL NOT pulse on the IDLE->slot 0 transition.
REQ-024 Nibble values 10..15 SHALL pass through to bcd_out unchanged; for blanking they are nonzero.
REQ-025 The guard counter SHALL be wide enough for GUARD_CYCLES with no overflow.

Reset
REQ-026 reset SHALL take precedence over tick in the same cycle.
REQ-027 After reset: state=IDLE, AN=8'hFF, bcd_out=4'h0, digit_idx=0, frame_done=0, guard counter=0, snapshot cleared to zero.
REQ-028 reset asserted in any state (including mid-GUARD or mid-frame) SHALL produce the REQ-027 values on the next clock edge; the scan restarts from IDLE.

Verification
REQ-029 GUARD_CYCLES=4, digits=32'h76543210, digit_en=8'hFF, blank_lz=0, tick every 20 cycles -> AN low bits cycle FE,FD,FB,...,7F; bcd_out 0..7; AN=FF for 4 cycles after each tick; frame_done after the 8th advance.
REQ-030 blank_lz=1, digits=32'h00000120 -> digits 3..7 AN stay FF in their slots; digits 0..2 lit with bcd_out 0,2,1; digit 0 lit even when digits=0.
REQ-031 digits changed from 32'h11111111 to 32'h22222222 while digit_idx=3 -> slots 4..7 still show 1; slot 0 of next frame shows 2.
REQ-032 Tick during GUARD (2 cycles after a tick) -> ignored, digit_idx unchanged, ON entered on schedule.
REQ-033 GUARD_CYCLES=0 -> AN low at t+1 of each tick; never two AN bits low.
REQ-034 reset during GUARD at digit_idx=5 with simultaneous tick -> next cycle AN=FF, digit_idx=0, state IDLE; next tick starts slot 0 with a new snapshot.
